// File: rtl/traffic_intersection_ctrl_pkg.sv
// Shared types for the intersection controller: phase encoding, lamp triple,
// and per-phase duration select.
package traffic_pkg;

  typedef enum logic [2:0] {
    CLR_NS    = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    CLR_EW    = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    PED_WALK  = 3'd6,
    FLASH     = 3'd7
  } phase_t;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  localparam lamp_t LAMP_OFF    = 3'b000;
  localparam lamp_t LAMP_RED    = 3'b100;
  localparam lamp_t LAMP_YELLOW = 3'b010;
  localparam lamp_t LAMP_GREEN  = 3'b001;

  // FLASH is untimed; it maps to the clearance length so the load is harmless.
  function automatic int unsigned phase_cycles(
    input phase_t      p,
    input int unsigned ns_green,
    input int unsigned ew_green,
    input int unsigned yellow,
    input int unsigned clear,
    input int unsigned walk
  );
    case (p)
      NS_GREEN:            return ns_green;
      EW_GREEN:            return ew_green;
      NS_YELLOW,
      EW_YELLOW:           return yellow;
      PED_WALK:            return walk;
      default:             return clear;
    endcase
  endfunction

endpackage

// File: rtl/traffic_intersection_ctrl_phase_timer.sv
// Loadable down-counter that stops at zero; done is high while the count is zero.
module phase_timer #(
  parameter int                 TIMER_W   = 8,
  parameter logic [TIMER_W-1:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               done
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= RESET_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection sequencer with clearance, latched pedestrian walk and
// flashing-yellow mode; lamps decode directly from the state register.
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int TIMER_W           = 8,
  parameter int NS_GREEN_CYCLES   = 20,
  parameter int EW_GREEN_CYCLES   = 20,
  parameter int YELLOW_CYCLES     = 4,
  parameter int CLEAR_CYCLES      = 2,
  parameter int WALK_CYCLES       = 10,
  parameter int FLASH_HALF_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flash_en,
  input  logic       ped_req,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  localparam logic [TIMER_W-1:0] CLEAR_LOAD = TIMER_W'(CLEAR_CYCLES - 1);
  localparam logic [TIMER_W-1:0] FLASH_LOAD = TIMER_W'(FLASH_HALF_CYCLES - 1);

  phase_t             state;
  phase_t             next_state;
  logic               timer_done;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_val;
  logic               flash_done;
  logic               flash_load;
  logic               toggle;
  logic               enter_walk;
  lamp_t              ns_lamp;
  lamp_t              ew_lamp;

  always_comb begin
    next_state = state;
    if (flash_en) begin
      next_state = FLASH;
    end else begin
      case (state)
        CLR_NS:    if (timer_done) next_state = NS_GREEN;
        NS_GREEN:  if (timer_done) next_state = NS_YELLOW;
        NS_YELLOW: if (timer_done) next_state = CLR_EW;
        CLR_EW:    if (timer_done) next_state = EW_GREEN;
        EW_GREEN:  if (timer_done) next_state = EW_YELLOW;
        EW_YELLOW: if (timer_done) next_state = ped_pending ? PED_WALK : CLR_NS;
        PED_WALK:  if (timer_done) next_state = CLR_NS;
        default:   next_state = CLR_NS;
      endcase
    end
  end

  // Every state change reloads the phase timer with the new state's length.
  assign timer_load = (next_state != state);
  assign timer_val  = TIMER_W'(phase_cycles(next_state, NS_GREEN_CYCLES, EW_GREEN_CYCLES,
                                            YELLOW_CYCLES, CLEAR_CYCLES, WALK_CYCLES) - 1);
  assign flash_load = (next_state == FLASH) && ((state != FLASH) || flash_done);
  assign enter_walk = (state == EW_YELLOW) && (next_state == PED_WALK);

  phase_timer #(.TIMER_W(TIMER_W), .RESET_VAL(CLEAR_LOAD)) u_phase_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  phase_timer #(.TIMER_W(TIMER_W), .RESET_VAL('0)) u_flash_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (flash_load),
    .load_val (FLASH_LOAD),
    .done     (flash_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CLR_NS;
      ped_pending <= 1'b0;
      toggle      <= 1'b0;
    end else begin
      state       <= next_state;
      ped_pending <= ped_req | (ped_pending & ~enter_walk);
      if (next_state != FLASH) begin
        toggle <= 1'b0;
      end else if (state != FLASH) begin
        toggle <= 1'b1;
      end else if (flash_done) begin
        toggle <= ~toggle;
      end
    end
  end

  always_comb begin
    ns_lamp = LAMP_RED;
    ew_lamp = LAMP_RED;
    walk    = 1'b0;
    case (state)
      NS_GREEN:  ns_lamp = LAMP_GREEN;
      NS_YELLOW: ns_lamp = LAMP_YELLOW;
      EW_GREEN:  ew_lamp = LAMP_GREEN;
      EW_YELLOW: ew_lamp = LAMP_YELLOW;
      PED_WALK:  walk    = 1'b1;
      FLASH: begin
        ns_lamp        = LAMP_OFF;
        ew_lamp        = LAMP_OFF;
        ns_lamp.yellow = toggle;
        ew_lamp.yellow = toggle;
      end
      default: ;
    endcase
  end

  assign ns_red    = ns_lamp.red;
  assign ns_yellow = ns_lamp.yellow;
  assign ns_green  = ns_lamp.green;
  assign ew_red    = ew_lamp.red;
  assign ew_yellow = ew_lamp.yellow;
  assign ew_green  = ew_lamp.green;
  assign phase     = state;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed bench: table-driven round checks plus hand sequences for walk re-latch,
// flash mode and mid-cycle reset; a monitor checks lamp safety every cycle.
module tb_traffic_intersection_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       flash_en;
  logic       ped_req;
  logic       ns_red, ns_yellow, ns_green;
  logic       ew_red, ew_yellow, ew_green;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       f;
    logic       p;
    logic [2:0] ph;
    logic       pp;
  } vec_t;

  vec_t       tbl[$];
  logic [2:0] round_seq [13];
  logic [6:0] lamp_exp [7];

  traffic_intersection_ctrl #(
    .TIMER_W(8), .NS_GREEN_CYCLES(4), .EW_GREEN_CYCLES(3), .YELLOW_CYCLES(2),
    .CLEAR_CYCLES(1), .WALK_CYCLES(3), .FLASH_HALF_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .flash_en(flash_en), .ped_req(ped_req),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .walk(walk), .ped_pending(ped_pending), .phase(phase)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] lamps();
    return {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input logic [2:0] ph);
    int n = 0;
    while (phase !== ph && n < 40) begin
      step();
      n++;
    end
    check("run_until_phase", {5'b0, phase}, {5'b0, ph});
  endtask

  task automatic add(input logic f, input logic p, input logic [2:0] ph, input logic pp);
    vec_t v;
    v.f = f; v.p = p; v.ph = ph; v.pp = pp;
    tbl.push_back(v);
  endtask

  // Safety monitor: no conflicting vehicle movements, no green while flashing.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      if ((phase != 3'd7 && (ns_green | ns_yellow) && (ew_green | ew_yellow)) ||
          (phase == 3'd7 && (ns_green | ew_green))) begin
        errors++;
        $display("FAIL safety: phase=%0d lamps=%b", phase, lamps());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    round_seq = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5, 3'd5, 3'd0};
    // {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g,walk} per phase 0..6
    lamp_exp = '{7'b1001000, 7'b0011000, 7'b0101000, 7'b1001000,
                 7'b1000010, 7'b1000100, 7'b1001001};

    // Round 1: free run.
    for (int k = 0; k < 13; k++) add(1'b0, 1'b0, round_seq[k], 1'b0);
    // Round 2: one-cycle press during NS_GREEN, walk served after EW_YELLOW.
    add(1'b0, 1'b0, 3'd1, 1'b0);
    add(1'b0, 1'b1, 3'd1, 1'b1);
    for (int k = 2; k < 12; k++) add(1'b0, 1'b0, round_seq[k], 1'b1);
    for (int k = 0; k < 3; k++) add(1'b0, 1'b0, 3'd6, 1'b0);
    add(1'b0, 1'b0, 3'd0, 1'b0);
    // Round 3: no walk.
    for (int k = 0; k < 13; k++) add(1'b0, 1'b0, round_seq[k], 1'b0);

    reset = 1'b1; flash_en = 1'b0; ped_req = 1'b0;
    repeat (3) step();
    check("reset_phase", {5'b0, phase}, 8'd0);
    check("reset_lamps", {1'b0, lamps()}, 8'b01001000);
    check("reset_pending", {7'b0, ped_pending}, 8'd0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      flash_en = tbl[i].f;
      ped_req  = tbl[i].p;
      step();
      check($sformatf("tbl%0d_phase", i), {5'b0, phase}, {5'b0, tbl[i].ph});
      check($sformatf("tbl%0d_lamps", i), {1'b0, lamps()}, {1'b0, lamp_exp[tbl[i].ph]});
      check($sformatf("tbl%0d_pending", i), {7'b0, ped_pending}, {7'b0, tbl[i].pp});
    end
    ped_req = 1'b0; flash_en = 1'b0;

    // Press on the EW_YELLOW->PED_WALK edge stays pending for the next round.
    step();
    ped_req = 1'b1; step(); ped_req = 1'b0;
    run_until(3'd5);
    step();
    check("edge_last_yellow", {5'b0, phase}, 8'd5);
    ped_req = 1'b1; step(); ped_req = 1'b0;
    check("edge_walk_phase", {5'b0, phase}, 8'd6);
    check("edge_pending_kept", {7'b0, ped_pending}, 8'd1);
    step(); step();
    check("edge_walk3", {5'b0, phase}, 8'd6);
    step();
    check("edge_back_clr", {5'b0, phase}, 8'd0);
    check("edge_pending_still", {7'b0, ped_pending}, 8'd1);
    run_until(3'd5);
    step(); step();
    check("second_walk_phase", {5'b0, phase}, 8'd6);
    check("second_walk_lamp", {7'b0, walk}, 8'd1);
    check("second_walk_cleared", {7'b0, ped_pending}, 8'd0);

    // Flash entered mid NS_GREEN with a request pending.
    run_until(3'd1);
    ped_req = 1'b1; step(); ped_req = 1'b0;
    flash_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [5:0] ypat;
      ypat = 6'b110011;
      step();
      check($sformatf("flash%0d_phase", i), {5'b0, phase}, 8'd7);
      check($sformatf("flash%0d_lamps", i), {1'b0, lamps()},
            {2'b00, ypat[5-i], 2'b00, ypat[5-i], 2'b00});
    end
    check("flash_pending_held", {7'b0, ped_pending}, 8'd1);
    flash_en = 1'b0; step();
    check("flash_exit_clr", {5'b0, phase}, 8'd0);
    check("flash_exit_lamps", {1'b0, lamps()}, 8'b01001000);
    flash_en = 1'b1; step();
    check("flash_reenter", {5'b0, phase}, 8'd7);
    check("flash_reenter_yel", {6'b0, ns_yellow, ew_yellow}, 8'd3);
    flash_en = 1'b0; step();
    check("flash_exit2_clr", {5'b0, phase}, 8'd0);
    step();
    check("flash_exit2_green", {5'b0, phase}, 8'd1);

    // Reset mid EW_GREEN with a request pending, then a clean free-run round.
    run_until(3'd4);
    check("pre_reset_pending", {7'b0, ped_pending}, 8'd1);
    reset = 1'b1; step(); reset = 1'b0;
    check("midreset_phase", {5'b0, phase}, 8'd0);
    check("midreset_pending", {7'b0, ped_pending}, 8'd0);
    check("midreset_lamps", {1'b0, lamps()}, 8'b01001000);
    for (int k = 0; k < 13; k++) begin
      step();
      check($sformatf("restart%0d", k), {5'b0, phase}, {5'b0, round_seq[k]});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
